// File: rtl/i2s_tx_fifo.sv
// I2S / left-justified serial audio transmitter with a small stereo sample FIFO.
// Bit timing comes from the shared master counter. A frame is loaded at the
// load point and shifted out MSB first, one bit per bclk period.
module i2s_tx_fifo #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SLOT_LOG2 = 4,
  parameter int unsigned BCLK_LOG2 = 5,
  parameter int unsigned FIFO_AW   = 2,
  localparam int unsigned CNT_W    = BCLK_LOG2 + SLOT_LOG2 + 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [CNT_W-1:0]  master_count_in,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              data_valid_in,
  output logic              ready_out,
  input  logic              mode_in,
  input  logic              mute_in,
  input  logic              underrun_clr_in,
  output logic              underrun_out,
  output logic [FIFO_AW:0]  fifo_level_out,
  output logic              d_out,
  output logic              ws_out,
  output logic              bclk_out
);

  localparam int unsigned SLOT_W  = 1 << SLOT_LOG2;
  localparam int unsigned FRAME_W = 2 * SLOT_W;
  localparam int unsigned PAD_W   = SLOT_W - DATA_W;
  localparam int unsigned DEPTH   = 1 << FIFO_AW;
  localparam int unsigned POS_W   = SLOT_LOG2 + 1;
  localparam int unsigned PTR_W   = FIFO_AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } sample_t;

  sample_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   level_q, level_d;
  logic               ready_q, ready_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               mode_q, mode_d;
  logic               primed_q, primed_d;
  logic               underrun_q, underrun_d;

  logic               tick_c;
  logic [POS_W-1:0]   pos_c;
  logic               frame_start_c;
  logic               frame_end_c;
  logic               load_c;
  logic               empty_c;
  logic               full_c;
  logic               push_c;
  logic               pop_c;
  logic               underrun_set_c;
  sample_t            head_c;
  logic [SLOT_W-1:0]  l_slot_c;
  logic [SLOT_W-1:0]  r_slot_c;

  // Serial clocks straight from the master counter, independent of reset.
  assign bclk_out = master_count_in[BCLK_LOG2-1];
  assign ws_out   = master_count_in[CNT_W-1];

  // Frame timing decode: tick is the last clk of each bclk period.
  assign tick_c        = &master_count_in[BCLK_LOG2-1:0];
  assign pos_c         = master_count_in[CNT_W-1:BCLK_LOG2];
  assign frame_start_c = tick_c && (pos_c == '0);
  assign frame_end_c   = tick_c && (pos_c == POS_W'(FRAME_W - 1));
  assign load_c        = mode_q ? frame_end_c : frame_start_c;

  // FIFO status; full and empty come from registered pointers only.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign push_c  = data_valid_in && !full_c;
  assign pop_c   = load_c && !empty_c;

  // Head entry placed MSB-aligned in its slot with zero padding below.
  assign head_c   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign l_slot_c = SLOT_W'(head_c.left) << PAD_W;
  assign r_slot_c = SLOT_W'(head_c.right) << PAD_W;

  // An empty load only counts as underrun once the stream has started.
  assign underrun_set_c = load_c && empty_c && primed_q;

  // Next-state logic for pointers, shifter, flags and effective mode.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sr_d       = sr_q;
    mode_d     = mode_q;
    primed_d   = primed_q;
    underrun_d = underrun_q;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      primed_d = 1'b1;
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (load_c) begin
      if (!empty_c && !mute_in) begin
        sr_d = {l_slot_c, r_slot_c};
      end else begin
        sr_d = '0;
      end
    end else if (tick_c) begin
      sr_d = {sr_q[FRAME_W-2:0], 1'b0};
    end

    if (frame_end_c) begin
      mode_d = mode_in;
    end

    if (underrun_set_c) begin
      underrun_d = 1'b1;
    end else if (underrun_clr_in) begin
      underrun_d = 1'b0;
    end

    level_d = level_q + PTR_W'(push_c) - PTR_W'(pop_c);
    ready_d = (level_d != PTR_W'(DEPTH));
  end

  // Control and datapath registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      sr_q       <= '0;
      mode_q     <= 1'b0;
      primed_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      sr_q       <= sr_d;
      mode_q     <= mode_d;
      primed_q   <= primed_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk_in) begin
    if (push_c) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= '{left: left_in, right: right_in};
    end
  end

  assign ready_out      = ready_q;
  assign fifo_level_out = level_q;
  assign underrun_out   = underrun_q;
  assign d_out          = sr_q[FRAME_W-1];

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Bench for i2s_tx_fifo: directed scenarios plus random traffic, with a
// stream-level reference model feeding a per-cycle scoreboard.
module tb_i2s_tx_fifo;

  localparam int DATA_W    = 12;
  localparam int SLOT_LOG2 = 4;
  localparam int BCLK_LOG2 = 3;
  localparam int FIFO_AW   = 2;
  localparam int CNT_W     = BCLK_LOG2 + SLOT_LOG2 + 1;
  localparam int BDIV      = 2 ** BCLK_LOG2;
  localparam int S         = 2 ** SLOT_LOG2;
  localparam int FRAME     = 2 * S;
  localparam int DEPTH     = 2 ** FIFO_AW;
  localparam int FRAME_CYC = 2 ** CNT_W;

  logic              clk_in = 1'b0;
  logic              reset_in = 1'b1;
  logic [CNT_W-1:0]  master_count_in = '0;
  logic [DATA_W-1:0] left_in = '0;
  logic [DATA_W-1:0] right_in = '0;
  logic              data_valid_in = 1'b0;
  logic              ready_out;
  logic              mode_in = 1'b0;
  logic              mute_in = 1'b0;
  logic              underrun_clr_in = 1'b0;
  logic              underrun_out;
  logic [FIFO_AW:0]  fifo_level_out;
  logic              d_out;
  logic              ws_out;
  logic              bclk_out;

  i2s_tx_fifo #(
    .DATA_W   (DATA_W),
    .SLOT_LOG2(SLOT_LOG2),
    .BCLK_LOG2(BCLK_LOG2),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .master_count_in (master_count_in),
    .left_in         (left_in),
    .right_in        (right_in),
    .data_valid_in   (data_valid_in),
    .ready_out       (ready_out),
    .mode_in         (mode_in),
    .mute_in         (mute_in),
    .underrun_clr_in (underrun_clr_in),
    .underrun_out    (underrun_out),
    .fifo_level_out  (fifo_level_out),
    .d_out           (d_out),
    .ws_out          (ws_out),
    .bclk_out        (bclk_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Clock and the free-running master counter (advances at each falling edge).
  initial begin
    forever begin
      #5 clk_in = 1'b1;
      #5 clk_in = 1'b0;
      master_count_in = master_count_in + CNT_W'(1);
    end
  end

  function automatic logic [FRAME-1:0] mkframe(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    logic [FRAME-1:0] f;
    f = (FRAME'(l) << (FRAME - DATA_W)) | (FRAME'(r) << (S - DATA_W));
    return f;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } entry_t;

  typedef struct {
    logic d;
    int   level;
    logic ready;
    logic ur;
  } exp_t;

  entry_t           fifo_m[$];
  exp_t             exp_q[$];
  logic [FRAME-1:0] frame_m = '0;
  int               bitidx_m = 0;
  logic             mode_m = 1'b0;
  logic             primed_m = 1'b0;
  logic             ur_m = 1'b0;

  int     m_cnt, m_pos;
  logic   m_tick, m_load, m_full, m_set_ur;
  entry_t m_e;
  exp_t   m_x;

  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      fifo_m.delete();
      exp_q.delete();
      frame_m  = '0;
      bitidx_m = 0;
      mode_m   = 1'b0;
      primed_m = 1'b0;
      ur_m     = 1'b0;
    end else begin
      m_cnt    = int'(master_count_in);
      m_tick   = (m_cnt % BDIV) == BDIV - 1;
      m_pos    = m_cnt / BDIV;
      m_load   = m_tick && (mode_m ? (m_pos == FRAME - 1) : (m_pos == 0));
      m_full   = (fifo_m.size() == DEPTH);
      m_set_ur = 1'b0;
      if (m_load) begin
        bitidx_m = 0;
        if (fifo_m.size() != 0) begin
          m_e     = fifo_m.pop_front();
          frame_m = mute_in ? '0 : mkframe(m_e.l, m_e.r);
        end else begin
          frame_m  = '0;
          m_set_ur = primed_m;
        end
      end else if (m_tick && bitidx_m < FRAME) begin
        bitidx_m++;
      end
      if (data_valid_in && !m_full) begin
        m_e.l = left_in;
        m_e.r = right_in;
        fifo_m.push_back(m_e);
        primed_m = 1'b1;
      end
      if (m_set_ur) ur_m = 1'b1;
      else if (underrun_clr_in) ur_m = 1'b0;
      if (m_tick && m_pos == FRAME - 1) mode_m = mode_in;
      m_x.d     = (bitidx_m < FRAME) ? frame_m[FRAME-1-bitidx_m] : 1'b0;
      m_x.level = fifo_m.size();
      m_x.ready = (fifo_m.size() < DEPTH);
      m_x.ur    = ur_m;
      exp_q.push_back(m_x);
    end
  end

  exp_t mon_x;

  // Monitor: compare DUT outputs just after each active edge.
  always begin
    @(posedge clk_in);
    #1;
    if (!reset_in && exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      chk("sb_d_out", 64'(d_out), 64'(mon_x.d));
      chk("sb_level", 64'(fifo_level_out), 64'(mon_x.level));
      chk("sb_ready", 64'(ready_out), 64'(mon_x.ready));
      chk("sb_underrun", 64'(underrun_out), 64'(mon_x.ur));
      chk("sb_ws", 64'(ws_out), 64'(int'(master_count_in) >= FRAME_CYC / 2));
      chk("sb_bclk", 64'(bclk_out), 64'((int'(master_count_in) % BDIV) >= BDIV / 2));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Step to the falling edge after which the counter holds c (bounded).
  task automatic wait_count(input int c);
    int n = 0;
    do begin
      @(negedge clk_in);
      #1;
      n++;
    end while (int'(master_count_in) != c && n < FRAME_CYC + 4);
    if (int'(master_count_in) != c) chk("wait_count_timeout", 64'(master_count_in), 64'(c));
  endtask

  // Collect one frame of d_out, sampled mid-bclk from position p0 on.
  task automatic capture(input int p0, output logic [FRAME-1:0] w);
    w = '0;
    for (int i = 0; i < FRAME; i++) begin
      wait_count(((p0 + i) % FRAME) * BDIV + BDIV / 2);
      w = {w[FRAME-2:0], d_out};
    end
  endtask

  logic [FRAME-1:0]  w;
  logic [DATA_W-1:0] bp_l [DEPTH];
  logic [DATA_W-1:0] bp_r [DEPTH];

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    #1;
    chk("rst_d_out", 64'(d_out), 64'd0);
    chk("rst_level", 64'(fifo_level_out), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_underrun", 64'(underrun_out), 64'd0);
    wait_count(250);
    reset_in = 1'b0;

    // I2S frame
    wait_count(0);
    data_valid_in = 1'b1;
    left_in  = 12'hA5F;
    right_in = 12'h0F0;
    wait_count(1);
    data_valid_in = 1'b0;
    chk("i2s_level_after_write", 64'(fifo_level_out), 64'd1);
    capture(1, w);
    chk("i2s_frame", 64'(w), 64'h00000000_A5F00F00);
    chk("i2s_underrun", 64'(underrun_out), 64'd0);
    chk("i2s_level_drained", 64'(fifo_level_out), 64'd0);

    // Underrun, clear, and clear colliding with a new underrun
    capture(1, w);
    chk("ur_zero_frame", 64'(w), 64'd0);
    chk("ur_set", 64'(underrun_out), 64'd1);
    wait_count(20);
    underrun_clr_in = 1'b1;
    wait_count(21);
    underrun_clr_in = 1'b0;
    chk("ur_cleared", 64'(underrun_out), 64'd0);
    wait_count(7);
    underrun_clr_in = 1'b1;
    wait_count(8);
    underrun_clr_in = 1'b0;
    chk("ur_set_beats_clear", 64'(underrun_out), 64'd1);

    // Back-pressure: four writes fill, fifth ignored
    wait_count(19);
    for (int i = 0; i < DEPTH; i++) begin
      wait_count(20 + i);
      bp_l[i] = DATA_W'($urandom);
      bp_r[i] = DATA_W'($urandom);
      data_valid_in = 1'b1;
      left_in  = bp_l[i];
      right_in = bp_r[i];
    end
    wait_count(20 + DEPTH);
    left_in  = 12'hFFF;
    right_in = 12'hFFF;
    chk("bp_level_full", 64'(fifo_level_out), 64'(DEPTH));
    chk("bp_ready_low", 64'(ready_out), 64'd0);
    wait_count(21 + DEPTH);
    data_valid_in = 1'b0;
    chk("bp_fifth_ignored", 64'(fifo_level_out), 64'(DEPTH));
    wait_count(8);
    chk("bp_level_after_load", 64'(fifo_level_out), 64'(DEPTH - 1));
    chk("bp_ready_after_load", 64'(ready_out), 64'd1);
    capture(1, w);
    chk("bp_first_frame", 64'(w), 64'(mkframe(bp_l[0], bp_r[0])));
    for (int i = 1; i < DEPTH; i++) wait_count(8);
    chk("bp_drained", 64'(fifo_level_out), 64'd0);

    // Left-justified frame
    mode_in = 1'b1;
    wait_count(FRAME_CYC - 1);
    wait_count(0);
    data_valid_in = 1'b1;
    left_in  = 12'hABC;
    right_in = 12'h123;
    wait_count(1);
    data_valid_in = 1'b0;
    wait_count(FRAME_CYC - 1);
    capture(0, w);
    chk("lj_frame", 64'(w), 64'h00000000_ABC01230);

    // Mute: entry consumed, zeros sent, no underrun
    mode_in = 1'b0;
    wait_count(FRAME_CYC - 1);
    wait_count(8);
    underrun_clr_in = 1'b1;
    wait_count(9);
    underrun_clr_in = 1'b0;
    mute_in = 1'b1;
    data_valid_in = 1'b1;
    left_in  = 12'h7FF;
    right_in = 12'h800;
    wait_count(10);
    data_valid_in = 1'b0;
    chk("mute_level_1", 64'(fifo_level_out), 64'd1);
    chk("mute_ur_before", 64'(underrun_out), 64'd0);
    wait_count(8);
    mute_in = 1'b0;
    chk("mute_level_0", 64'(fifo_level_out), 64'd0);
    chk("mute_ur_after_load", 64'(underrun_out), 64'd0);
    capture(1, w);
    chk("mute_frame_zero", 64'(w), 64'd0);
    chk("mute_ur_end", 64'(underrun_out), 64'd0);

    // Reset mid-frame with two entries queued
    wait_count(0);
    data_valid_in = 1'b1;
    left_in  = 12'hFFF;
    right_in = 12'hFFF;
    wait_count(3);
    data_valid_in = 1'b0;
    wait_count(5 * BDIV);
    chk("mid_level_before", 64'(fifo_level_out), 64'd2);
    chk("mid_d_before", 64'(d_out), 64'd1);
    reset_in = 1'b1;
    #1;
    chk("mid_rst_d_out", 64'(d_out), 64'd0);
    chk("mid_rst_level", 64'(fifo_level_out), 64'd0);
    chk("mid_rst_ready", 64'(ready_out), 64'd1);
    wait_count(6 * BDIV + 2);
    reset_in = 1'b0;
    capture(1, w);
    chk("post_rst_frame_zero", 64'(w), 64'd0);
    chk("post_rst_ur", 64'(underrun_out), 64'd0);
    wait_count(8);
    chk("post_rst_ur_2", 64'(underrun_out), 64'd0);

    // Random traffic: alternating heavy and light write phases
    for (int k = 0; k < 8000; k++) begin
      int rate;
      @(negedge clk_in);
      #1;
      rate = ((k / 1000) % 2 == 0) ? 25 : 3;
      data_valid_in   = ($urandom_range(0, 999) < rate);
      left_in         = DATA_W'($urandom);
      right_in        = DATA_W'($urandom);
      mute_in         = ($urandom_range(0, 15) == 0);
      underrun_clr_in = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1499) == 0) mode_in = ~mode_in;
    end
    data_valid_in   = 1'b0;
    mute_in         = 1'b0;
    underrun_clr_in = 1'b0;
    repeat (2 * FRAME_CYC) @(negedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_fifo.md
# i2s_tx_fifo

Parametrised I2S/left-justified serial audio transmitter with an internal sample FIFO. It replaces the single-entry stereo output stage between the tone-generator mixer and the external DAC. Serial timing is derived from the shared free-running master counter. Added over the previous generation: configurable sample and slot widths, a selectable frame format, a multi-entry FIFO with valid/ready flow control, mute, and underrun reporting.

## Interface
- DATA_W, 16: sample bits per channel, 1..SLOT_W
- SLOT_LOG2, 4: log2 of bclk periods per channel slot (SLOT_W = 2^SLOT_LOG2)
- BCLK_LOG2, 5: log2 of clk_in cycles per bclk period
- FIFO_AW, 2: log2 FIFO depth (depth 4)
- Derived: CNT_W = BCLK_LOG2 + SLOT_LOG2 + 1

Ports:
- clk_in  in  1  system clock
- reset_in  in  1  reset, asynchronous, active-high
- master_count_in  in  CNT_W  shared free-running counter, increments by 1 each clk_in
- left_in  in  DATA_W  left sample, two's complement
- right_in  in  DATA_W  right sample
- data_valid_in  in  1  write request
- ready_out  out  1  FIFO not full; a write is accepted when data_valid_in && ready_out
- mode_in  in  1  0 = I2S (MSB one bclk after ws edge), 1 = left-justified
- mute_in  in  1  transmit zeros while still consuming FIFO entries
- underrun_clr_in  in  1  clears underrun_out
- underrun_out  out  1  sticky underrun flag
- fifo_level_out  out  FIFO_AW+1  current FIFO occupancy
- d_out  out  1  serial data, MSB first
- ws_out  out  1  word select, 0 = left
- bclk_out  out  1  bit clock

## Operation
- bclk_out = master_count_in[BCLK_LOG2-1]. ws_out = master_count_in[CNT_W-1]. Both are combinational and reset-independent.
- tick = (master_count_in[BCLK_LOG2-1:0] == all ones), i.e. the last clk of each bclk period. pos = master_count_in[CNT_W-1:BCLK_LOG2] is the frame bit position, 0..2*SLOT_W-1.
- Frame word, 2*SLOT_W bits: {left, zeros(SLOT_W-DATA_W), right, zeros(SLOT_W-DATA_W)}. d_out = shift register MSB.
- Load point:
  - I2S mode: tick with pos == 0.
  - LJ mode: tick with pos == 2*SLOT_W-1.
  - Every other tick shifts left by one, inserting 0.
- At the load point:
  - FIFO non-empty: pop the head entry and load the frame word, or zeros if mute_in = 1.
  - FIFO empty: load zeros, and set underrun_out if the primed flag is set.
- primed is set by the first accepted write and cleared only by reset.
- Mode latching: mode_in is sampled into an effective-mode register at every tick with pos == 2*SLOT_W-1. A change therefore takes effect from the next frame. In I2S mode that frame's load at pos 0 uses the new mode.
- FIFO:
  - Circular buffer with pointers of width FIFO_AW+1.
  - ready_out = !full, computed from registered state only. A write while full is ignored, even if a pop occurs in the same cycle.
  - Simultaneous write and pop when the FIFO is non-empty and not full: level is unchanged.
  - Write while empty and load point in the same cycle: the pop sees empty, so zeros are sent, underrun is evaluated, and the write is stored.
- underrun_clr_in clears underrun_out. If a clear coincides with a new underrun event, the set wins.

## Timing
- Reset (async assert, release synchronous to clk_in): d_out = 0, shift register = 0, FIFO empty, fifo_level_out = 0, ready_out = 1, underrun_out = 0, primed = 0, effective mode = 0 (I2S).
- A write accepted on cycle N appears in fifo_level_out on N+1. Its earliest use is the first load point at or after N+1.
- d_out changes on the clk edge ending the tick cycle, i.e. coincident with bclk falling. The DAC samples it on the following bclk rise.
- In I2S mode, the left MSB occupies bclk pos 1 and the right MSB occupies pos SLOT_W+1. The last right bit is driven during pos 0 of the next frame.
- In LJ mode, the left MSB occupies pos 0 and the right MSB occupies pos SLOT_W.
- Sustained sample rate is one entry per 2^(CNT_W) clk_in cycles.
- Reset asserted mid-frame: d_out is 0 immediately and the buffered samples are lost. Output resumes at the next load point.

## Test plan
- Defaults, I2S: write {A5F0, 0F0F} with count at 0. Required: d_out carries A5F0 MSB-first over bclk pos 1..16 and 0F0F over pos 17..31 plus next pos 0; ws_out is 0 for pos 0..15; underrun_out stays 0 for that frame.
- LJ, DATA_W=12, SLOT_LOG2=4: write {ABC, 123}. Required: d_out = ABC over pos 0..11, 0 over pos 12..15, 123 over pos 16..27, 0 over pos 28..31.
- Back-pressure: write 4 entries back-to-back with no load point. Required: fifo_level_out = 4 and ready_out = 0; a 5th write is ignored; after one load point, level = 3 and ready_out = 1.
- Underrun: one write, then two frames. Required: second frame is all-zero data and underrun_out = 1. underrun_clr_in pulse clears it; clear coincident with a new underrun event leaves it at 1.
- Mute: write {7FFF, 8000} with mute_in = 1. Required: frame is all zeros, level drops 1 → 0, underrun_out stays 0.
- Reset mid-frame at pos 5 with 2 entries queued. Required: d_out = 0, level = 0, ready_out = 1 immediately; after release, frames are zero and underrun_out stays 0 because primed was cleared.
